gate_a_ctrl: RTL and testbench

GATE_A_CTRL -- requirements
Module: gate_a_ctrl

---
 rtl/gate_a_ctrl.sv | 141 ++++++++++++++
 tb/tb_gate_a_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gate_a_ctrl.sv
// Gate A controller: lifts and lowers a sliding gate one step per video frame,
// holds it open for a fixed number of frames, then closes it automatically.
module gate_a_ctrl #(
    parameter logic [10:0] GATE_X        = 11'd300,
    parameter logic [10:0] GATE_Y_CLOSED = 11'd100,
    parameter int unsigned TRAVEL        = 18,
    parameter int unsigned STEP          = 2,
    parameter int unsigned HOLD_FRAMES   = 120
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        open_cmd,
    input  logic        close_cmd,
    output logic [10:0] ObjectStartX,
    output logic [10:0] ObjectStartY,
    output logic [1:0]  gate_state,
    output logic        gate_blocking,
    output logic        gate_open
);

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } gate_state_t;

    localparam logic [5:0] TRAVEL_L = 6'(TRAVEL);
    localparam logic [5:0] STEP_L   = 6'(STEP);
    localparam logic [9:0] HOLD_L   = 10'(HOLD_FRAMES);

    gate_state_t state_q, state_nxt;
    logic [5:0]  offset_q, offset_nxt;
    logic [9:0]  hold_q, hold_nxt;

    logic [10:0] y_nxt;
    logic        blocking_nxt;
    logic        open_nxt;

    // Close wins when both commands arrive together.
    logic cmd_close, cmd_open, any_cmd;
    logic [6:0] up_sum;

    assign cmd_close = close_cmd;
    assign cmd_open  = open_cmd & ~close_cmd;
    assign any_cmd   = open_cmd | close_cmd;
    assign up_sum    = {1'b0, offset_q} + {1'b0, STEP_L};

    // State, offset, hold counter and registered outputs.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q       <= CLOSED;
            offset_q      <= '0;
            hold_q        <= '0;
            ObjectStartX  <= GATE_X;
            ObjectStartY  <= GATE_Y_CLOSED;
            gate_state    <= CLOSED;
            gate_blocking <= 1'b1;
            gate_open     <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            offset_q      <= offset_nxt;
            hold_q        <= hold_nxt;
            ObjectStartX  <= GATE_X;
            ObjectStartY  <= y_nxt;
            gate_state    <= state_nxt;
            gate_blocking <= blocking_nxt;
            gate_open     <= open_nxt;
        end
    end

    // Next state: any command in a cycle suppresses that cycle's frame update.
    always_comb begin
        state_nxt  = state_q;
        offset_nxt = offset_q;
        hold_nxt   = hold_q;
        if (enable) begin
            case (state_q)
                CLOSED: begin
                    offset_nxt = '0;
                    if (cmd_open)
                        state_nxt = OPENING;
                end
                OPENING: begin
                    if (cmd_close) begin
                        state_nxt = CLOSING;
                    end else if (!any_cmd && startOfFrame) begin
                        if (up_sum >= {1'b0, TRAVEL_L}) begin
                            offset_nxt = TRAVEL_L;
                            state_nxt  = OPEN;
                            hold_nxt   = HOLD_L;
                        end else begin
                            offset_nxt = up_sum[5:0];
                        end
                    end
                end
                OPEN: begin
                    if (cmd_close) begin
                        state_nxt = CLOSING;
                    end else if (cmd_open) begin
                        hold_nxt = HOLD_L;
                    end else if (startOfFrame) begin
                        if (hold_q <= 10'd1) begin
                            hold_nxt  = '0;
                            state_nxt = CLOSING;
                        end else begin
                            hold_nxt = hold_q - 10'd1;
                        end
                    end
                end
                CLOSING: begin
                    if (cmd_open) begin
                        state_nxt = OPENING;
                    end else if (!any_cmd && startOfFrame) begin
                        if (offset_q <= STEP_L) begin
                            offset_nxt = '0;
                            state_nxt  = CLOSED;
                        end else begin
                            offset_nxt = offset_q - STEP_L;
                        end
                    end
                end
                default: begin
                    state_nxt  = CLOSED;
                    offset_nxt = '0;
                    hold_nxt   = '0;
                end
            endcase
        end
    end

    // Output values derived from the next state so they land in the following cycle.
    always_comb begin
        y_nxt        = GATE_Y_CLOSED - {5'd0, offset_nxt};
        blocking_nxt = (state_nxt != OPEN);
        open_nxt     = (state_nxt == OPEN);
    end

endmodule

// File: tb/tb_gate_a_ctrl.sv
// Bench for gate_a_ctrl: table of per-cycle vectors plus hand sequences,
// with expectations queued at drive time and popped after the clock edge.
module tb_gate_a_ctrl;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        enable = 1'b0;
    logic        open_cmd = 1'b0;
    logic        close_cmd = 1'b0;
    logic [10:0] ObjectStartX;
    logic [10:0] ObjectStartY;
    logic [1:0]  gate_state;
    logic        gate_blocking;
    logic        gate_open;

    gate_a_ctrl #(
        .GATE_X(11'd300),
        .GATE_Y_CLOSED(11'd100),
        .TRAVEL(18),
        .STEP(4),
        .HOLD_FRAMES(3)
    ) dut (
        .CLK(CLK),
        .RESETn(RESETn),
        .startOfFrame(startOfFrame),
        .enable(enable),
        .open_cmd(open_cmd),
        .close_cmd(close_cmd),
        .ObjectStartX(ObjectStartX),
        .ObjectStartY(ObjectStartY),
        .gate_state(gate_state),
        .gate_blocking(gate_blocking),
        .gate_open(gate_open)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic        sof;
        logic        op;
        logic        cl;
        logic [10:0] y;
        logic [1:0]  st;
    } vec_t;

    typedef struct {
        string       name;
        logic [10:0] y;
        logic [1:0]  st;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic en, logic sof, logic op, logic cl,
                                int y, int st);
        vec_t v;
        v.en = en; v.sof = sof; v.op = op; v.cl = cl;
        v.y = 11'(y); v.st = 2'(st);
        return v;
    endfunction

    // Compare all outputs against one expectation; blocking/open follow the state.
    task automatic check(input string name, input logic [10:0] y, input logic [1:0] st);
        logic exp_blk, exp_opn;
        exp_blk = (st != 2'd2);
        exp_opn = (st == 2'd2);
        n_vec++;
        if (ObjectStartY !== y || gate_state !== st || gate_blocking !== exp_blk ||
            gate_open !== exp_opn || ObjectStartX !== 11'd300) begin
            n_err++;
            $display("FAIL %s: got Y=%0d st=%0d blk=%b open=%b X=%0d, want Y=%0d st=%0d blk=%b open=%b X=300",
                     name, ObjectStartY, gate_state, gate_blocking, gate_open, ObjectStartX,
                     y, st, exp_blk, exp_opn);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input string name, input logic en, input logic sof,
                        input logic op, input logic cl,
                        input logic [10:0] y, input logic [1:0] st);
        exp_t e;
        enable = en; startOfFrame = sof; open_cmd = op; close_cmd = cl;
        e.name = name; e.y = y; e.st = st;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        startOfFrame = 1'b0; open_cmd = 1'b0; close_cmd = 1'b0;
        e = sb.pop_front();
        check(e.name, e.y, e.st);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        tbl.push_back(mk(1,1,0,0,100,0)); // frame while closed: nothing
        tbl.push_back(mk(1,0,0,1,100,0)); // close while closed: nothing
        tbl.push_back(mk(1,1,1,0,100,1)); // open + frame: command only
        tbl.push_back(mk(1,1,0,0, 96,1));
        tbl.push_back(mk(1,0,0,0, 96,1)); // no frame: hold position
        tbl.push_back(mk(1,1,0,0, 92,1));
        tbl.push_back(mk(1,1,0,0, 88,1));
        tbl.push_back(mk(1,1,0,0, 84,1));
        tbl.push_back(mk(1,1,0,0, 82,2)); // saturate at TRAVEL -> OPEN
        tbl.push_back(mk(1,1,0,0, 82,2)); // hold 2
        tbl.push_back(mk(1,0,1,0, 82,2)); // reload hold 3
        tbl.push_back(mk(1,1,0,0, 82,2)); // hold 2
        tbl.push_back(mk(1,1,0,0, 82,2)); // hold 1
        tbl.push_back(mk(1,1,0,0, 82,3)); // hold 0 -> CLOSING
        tbl.push_back(mk(1,1,0,0, 86,3));
        tbl.push_back(mk(1,1,0,0, 90,3));
        tbl.push_back(mk(1,0,1,0, 90,1)); // reversal keeps offset
        tbl.push_back(mk(1,1,0,0, 86,1));
        tbl.push_back(mk(1,1,0,0, 82,2));
        tbl.push_back(mk(1,0,1,1, 82,3)); // both commands -> close
        tbl.push_back(mk(1,1,0,0, 86,3));
        tbl.push_back(mk(1,1,0,0, 90,3));
        tbl.push_back(mk(1,1,0,0, 94,3));
        tbl.push_back(mk(1,1,0,0, 98,3));
        tbl.push_back(mk(1,1,0,0,100,0)); // saturate at 0 -> CLOSED
        tbl.push_back(mk(1,1,0,0,100,0));
        tbl.push_back(mk(1,0,1,0,100,1));
        tbl.push_back(mk(1,1,0,0, 96,1));
        tbl.push_back(mk(1,1,0,1, 96,3)); // close in OPENING + frame: no move
        tbl.push_back(mk(1,1,0,0,100,0));

        // Reset state
        RESETn = 1'b0;
        #12;
        check("reset_state", 11'd100, 2'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK);
        #1;

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].en, tbl[i].sof, tbl[i].op, tbl[i].cl,
                 tbl[i].y, tbl[i].st);
        end

        // Freeze in OPENING at 92: frames and commands ignored.
        step("frz_open", 1, 0, 1, 0, 11'd100, 2'd1);
        step("frz_f1",   1, 1, 0, 0, 11'd96,  2'd1);
        step("frz_f2",   1, 1, 0, 0, 11'd92,  2'd1);
        for (int unsigned k = 0; k < 4; k++)
            step($sformatf("frz_hold%0d", k), 0, 1, k[0], k[1], 11'd92, 2'd1);
        step("frz_resume", 1, 1, 0, 0, 11'd88, 2'd1);

        // Asynchronous reset mid-OPENING, away from any clock edge.
        #2;
        RESETn = 1'b0;
        #1;
        check("async_reset", 11'd100, 2'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK);
        #1;
        for (int unsigned k = 0; k < 3; k++)
            step($sformatf("post_rst%0d", k), 1, 1, 0, 0, 11'd100, 2'd0);
        step("post_rst_open", 1, 0, 1, 0, 11'd100, 2'd1);
        step("post_rst_f1",   1, 1, 0, 0, 11'd96,  2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
